// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Start/done handshake; divide-by-zero reports all-ones quotient and passes the dividend through.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // acc is one bit wider than the operands: acc < divisor before the shift,
    // so the shifted value is < 2*divisor and always fits.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = (shifted >= {1'b0, dvs_q});
        acc_nxt = ge ? diff : shifted;
        q_nxt   = {q_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        dvs_d   = divisor;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_nxt;
                q_d   = q_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    quo_d   = q_nxt;
                    rem_d   = acc_nxt[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (WIDTH=8)
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Returns at the negedge following the accepting edge; operands are scrambled afterwards.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) begin
            e.a   = a;
            e.b   = b;
            e.q   = (b == 0) ? 8'hFF : 8'(a / b);
            e.r   = (b == 0) ? a : 8'(a % b);
            e.dbz = (b == 0);
            e.lat = (b == 0) ? 0 : 8;
            sb.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic collect(input string tag, input int lat0);
        int   lat;
        int   bcy;
        exp_t e;
        lat = lat0;
        bcy = lat0;
        while (!done && lat < 40) begin
            if (busy) bcy++;
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (!done || sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s timeout: done=%0b pending=%0d", tag, done, sb.size());
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat) begin
            miscompares++;
            $display("FAIL %s latency %0d/%0d: got %0d want %0d", tag, e.a, e.b, lat, e.lat);
        end
        vectors++;
        if (bcy !== e.lat) begin
            miscompares++;
            $display("FAIL %s busy_cycles %0d/%0d: got %0d want %0d", tag, e.a, e.b, bcy, e.lat);
        end
        vectors++;
        if (quotient !== e.q) begin
            miscompares++;
            $display("FAIL %s quotient %0d/%0d: got %0d want %0d", tag, e.a, e.b, quotient, e.q);
        end
        vectors++;
        if (remainder !== e.r) begin
            miscompares++;
            $display("FAIL %s remainder %0d/%0d: got %0d want %0d", tag, e.a, e.b, remainder, e.r);
        end
        vectors++;
        if (div_by_zero !== e.dbz) begin
            miscompares++;
            $display("FAIL %s div_by_zero %0d/%0d: got %0b want %0b", tag, e.a, e.b, div_by_zero, e.dbz);
        end
        if (!e.dbz) begin
            vectors++;
            if ((int'(quotient) * int'(e.b) + int'(remainder)) != int'(e.a) || remainder >= e.b) begin
                miscompares++;
                $display("FAIL %s invariant %0d/%0d: got q=%0d r=%0d", tag, e.a, e.b, quotient, remainder);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
            miscompares++;
            $display("FAIL %s done_width/hold: got done=%0b q=%0d r=%0d want done=0 q=%0d r=%0d",
                     tag, done, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        vectors++;
        if (seen != 0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s extra_done: got %0d pulses, %0d pending, want 0 and 0", tag, seen, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'b0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%0b done=%0b dbz=%0b q=%0d r=%0d want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        issue(8'd100, 8'd7, 1);
        collect("basic_100_7", 0);
        issue(8'd255, 8'd1, 1);
        collect("div_by_one", 0);
        issue(8'd5, 8'd9, 1);
        collect("small_dividend", 0);
        issue(8'd0, 8'd3, 1);
        collect("zero_dividend", 0);
    endtask

    task automatic test_div_by_zero();
        issue(8'd37, 8'd0, 1);
        collect("dbz_37", 0);
        issue(8'd10, 8'd3, 1);
        collect("dbz_cleared", 0);
    endtask

    task automatic test_restart_ignored();
        issue(8'd200, 8'd13, 1);
        @(negedge clk);
        issue(8'd9, 8'd2, 0);
        collect("restart_ignored", 3);
        expect_quiet("restart_ignored", 12);
    endtask

    task automatic test_reset_mid_calc();
        exp_t dropped;
        issue(8'd200, 8'd13, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'b0) begin
            miscompares++;
            $display("FAIL reset_mid_calc: got busy=%0b done=%0b dbz=%0b q=%0d r=%0d want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        dropped = sb.pop_front();
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("reset_abort", 12);
        issue(8'd50, 8'd5, 1);
        collect("after_reset", 0);
    endtask

    task automatic test_random_sweep();
        logic [7:0] a, b;
        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            if (i < 4) b = 8'(i);
            issue(a, b, 1);
            collect("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_restart_ignored();
        test_reset_mid_calc();
        test_random_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
